myalu_pipe: RTL and testbench

//  Parametrised, handshaked successor of the 16-bit 3-bit-opcode ALU. Accepts one

---
 rtl/myalu_pkg.sv | 19 +
 rtl/myalu_core.sv | 56 +++++
 rtl/myalu_pipe.sv | 139 +++++++++++++
 tb/tb_myalu_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/myalu_pkg.sv
// Shared opcode and FSM-state definitions for the handshaked ALU.
package myalu_pkg;

  localparam logic [2:0] OP_ADDU = 3'b000;
  localparam logic [2:0] OP_ADDS = 3'b001;
  localparam logic [2:0] OP_SUBU = 3'b010;
  localparam logic [2:0] OP_SUBS = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SRL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : myalu_pkg

// File: rtl/myalu_core.sv
// Combinational single-cycle datapath: add/sub/logic ops and shift-by-zero pass-through,
// producing result and carry/overflow/zero flags.
module myalu_core
  import myalu_pkg::*;
#(
  parameter int NUMBITS = 16
) (
  input  logic [NUMBITS-1:0] i_a,
  input  logic [NUMBITS-1:0] i_b,
  input  logic [2:0]         i_op,
  output logic [NUMBITS-1:0] o_result,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_zero
);

  localparam int MSB = NUMBITS - 1;

  logic [NUMBITS:0] w_sum;
  logic [NUMBITS:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_op)
      OP_ADDU: begin
        o_result = w_sum[MSB:0];
        o_carry  = w_sum[NUMBITS];
      end
      OP_ADDS: begin
        o_result   = w_sum[MSB:0];
        o_overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUBU: begin
        // The extra bit of the widened difference is the unsigned borrow.
        o_result = w_diff[MSB:0];
        o_carry  = w_diff[NUMBITS];
      end
      OP_SUBS: begin
        o_result   = w_diff[MSB:0];
        o_overflow = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      default: o_result = i_a;  // OP_SRL: operand arrives already shifted
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule : myalu_core

// File: rtl/myalu_pipe.sv
// Handshaked ALU: one op per valid/ready transfer, registered result and flags held
// until taken, plus a multi-cycle logical right shift (one bit per cycle).
module myalu_pipe
  import myalu_pkg::*;
#(
  parameter int NUMBITS = 16,
  parameter int SHW     = $clog2(NUMBITS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] result,
  output logic               carryout,
  output logic               overflow,
  output logic               zero,
  output logic               busy
);

  state_t             r_state;
  state_t             w_state_next;
  logic [NUMBITS-1:0] r_work;
  logic [SHW-1:0]     r_cnt;
  logic [NUMBITS-1:0] r_result;
  logic               r_carry;
  logic               r_overflow;
  logic               r_zero;

  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_out_fire;
  logic [SHW-1:0]     w_shamt;
  logic               w_is_long;
  logic               w_exec_last;
  logic               w_load_out;

  logic [NUMBITS-1:0] w_core_a;
  logic [2:0]         w_core_op;
  logic [NUMBITS-1:0] w_core_result;
  logic               w_core_carry;
  logic               w_core_overflow;
  logic               w_core_zero;

  assign w_shamt     = B[SHW-1:0];
  assign w_is_long   = (opcode == OP_SRL) && (w_shamt != '0);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = (r_state == ST_DONE) && out_ready;
  assign w_exec_last = (r_state == ST_EXEC) && (r_cnt == SHW'(1));
  assign w_load_out  = (w_in_fire && !w_is_long) || w_exec_last;

  // During EXEC the core sees the work register after its final shift, so the
  // last shift step and the flag computation share the same datapath.
  assign w_core_a  = (r_state == ST_EXEC) ? (r_work >> 1) : A;
  assign w_core_op = (r_state == ST_EXEC) ? OP_SRL : opcode;

  myalu_core #(
    .NUMBITS (NUMBITS)
  ) u_core (
    .i_a        (w_core_a),
    .i_b        (B),
    .i_op       (w_core_op),
    .o_result   (w_core_result),
    .o_carry    (w_core_carry),
    .o_overflow (w_core_overflow),
    .o_zero     (w_core_zero)
  );

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (w_in_fire) w_state_next = w_is_long ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: begin
        if (w_exec_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_in_ready = out_ready;
        if (w_out_fire) begin
          if (w_in_fire) w_state_next = w_is_long ? ST_EXEC : ST_DONE;
          else           w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_work <= '0;
      r_cnt  <= '0;
    end else if (w_in_fire && w_is_long) begin
      r_work <= A;
      r_cnt  <= w_shamt;
    end else if (r_state == ST_EXEC) begin
      r_work <= r_work >> 1;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end

  // Outputs only update on a load, so they hold while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_load_out) begin
      r_result   <= w_core_result;
      r_carry    <= w_core_carry;
      r_overflow <= w_core_overflow;
      r_zero     <= w_core_zero;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_EXEC) || (r_state == ST_DONE);
  assign result    = r_result;
  assign carryout  = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule : myalu_pipe

// File: tb/tb_myalu_pipe.sv
// Directed-vector bench for myalu_pipe (NUMBITS=16).
module tb_myalu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carryout;
  logic        overflow;
  logic        zero;
  logic        busy;

  int vec_count = 0;
  int err_count = 0;

  myalu_pipe #(.NUMBITS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one accept edge, then withdraw it.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A        = 16'hDEAD;
    B        = 16'hBEEF;
    opcode   = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; opcode = '0;
    #12;
    vec_count++;
    if ({out_valid, result, carryout, overflow, zero, busy} !== 21'd0) begin
      err_count++;
      $display("FAIL reset_outputs: got ov=%b res=%h c=%b o=%b z=%b busy=%b, want all 0",
               out_valid, result, carryout, overflow, zero, busy);
    end
    vec_count++;
    if (in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    reset = 1'b1;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_reset_mid_shift();
    bit seen = 0;
    issue(3'b111, 16'hFFFF, 16'h0009);
    tick(); tick();
    vec_count++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      err_count++;
      $display("FAIL midshift_exec: busy=%b in_ready=%b out_valid=%b want 1/0/0", busy, in_ready, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    vec_count++;
    if ({out_valid, result, carryout, overflow, zero, busy} !== 21'd0 || in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL midshift_reset: ov=%b res=%h busy=%b in_ready=%b want 0/0000/0/1",
               out_valid, result, busy, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    vec_count++;
    if (seen) begin
      err_count++;
      $display("FAIL midshift_no_result: out_valid pulsed after aborted op, want none");
    end
    $display("test_reset_mid_shift: done");
  endtask

  task automatic test_arith();
    issue(3'b000, 16'hFFFF, 16'h0001);
    vec_count++;
    if ({out_valid, result, carryout, overflow, zero} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
      err_count++;
      $display("FAIL addu: v=%b res=%h c=%b o=%b z=%b want 1 0000 1 0 1", out_valid, result, carryout, overflow, zero);
    end
    issue(3'b001, 16'h7FFF, 16'h0001);
    vec_count++;
    if ({out_valid, result, carryout, overflow, zero} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0}) begin
      err_count++;
      $display("FAIL adds: v=%b res=%h c=%b o=%b z=%b want 1 8000 0 1 0", out_valid, result, carryout, overflow, zero);
    end
    issue(3'b011, 16'h8000, 16'h0001);
    vec_count++;
    if ({out_valid, result, carryout, overflow, zero} !== {1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0}) begin
      err_count++;
      $display("FAIL subs: v=%b res=%h c=%b o=%b z=%b want 1 7fff 0 1 0", out_valid, result, carryout, overflow, zero);
    end
    issue(3'b010, 16'h0003, 16'h0005);
    vec_count++;
    if ({out_valid, result, carryout, overflow, zero} !== {1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0}) begin
      err_count++;
      $display("FAIL subu: v=%b res=%h c=%b o=%b z=%b want 1 fffe 1 0 0", out_valid, result, carryout, overflow, zero);
    end
    issue(3'b001, 16'h0005, 16'hFFFB);
    vec_count++;
    if ({out_valid, result, carryout, overflow, zero} !== {1'b1, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      err_count++;
      $display("FAIL adds_zero: v=%b res=%h c=%b o=%b z=%b want 1 0000 0 0 1", out_valid, result, carryout, overflow, zero);
    end
    tick();
    vec_count++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      err_count++;
      $display("FAIL arith_drain: out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
    $display("test_arith: done");
  endtask

  task automatic run_shift(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic exp_zero, input int exp_edges);
    int edges = 1;
    issue(3'b111, a, b);
    if (exp_edges > 1) begin
      vec_count++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
        err_count++;
        $display("FAIL %s_exec: in_ready=%b busy=%b out_valid=%b want 0/1/0", name, in_ready, busy, out_valid);
      end
    end
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    vec_count++;
    if (edges != exp_edges || result !== exp_res || zero !== exp_zero || carryout !== 1'b0 || overflow !== 1'b0) begin
      err_count++;
      $display("FAIL %s: edges=%0d res=%h z=%b c=%b o=%b want edges=%0d res=%h z=%b c=0 o=0",
               name, edges, result, zero, carryout, overflow, exp_edges, exp_res, exp_zero);
    end
    $display("shift %s: res=%h after %0d edges", name, result, edges);
  endtask

  task automatic test_shift();
    run_shift("srl4",  16'hF000, 16'h0004, 16'h0F00, 1'b0, 5);
    run_shift("srl0",  16'hF000, 16'h0000, 16'hF000, 1'b0, 1);
    run_shift("srl15", 16'hF000, 16'h000F, 16'h0001, 1'b0, 16);
    run_shift("srlz",  16'h0004, 16'hFFF3, 16'h0000, 1'b1, 4);
    tick();
    $display("test_shift: done");
  endtask

  task automatic test_backpressure();
    int transfers = 0;
    out_ready = 1'b0;
    issue(3'b100, 16'h00FF, 16'h0F0F);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; opcode = 3'b101; A = 16'h1234 + 16'(i); B = 16'h4321;
      vec_count++;
      if (out_valid !== 1'b1 || result !== 16'h000F || zero !== 1'b0 || in_ready !== 1'b0) begin
        err_count++;
        $display("FAIL bp_hold%0d: v=%b res=%h z=%b in_ready=%b want 1 000f 0 0", i, out_valid, result, zero, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    vec_count++;
    if (out_valid !== 1'b1 || result !== 16'h000F) begin
      err_count++;
      $display("FAIL bp_after_hold: v=%b res=%h want 1 000f", out_valid, result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) transfers++;
      tick();
    end
    vec_count++;
    if (transfers != 1) begin
      err_count++;
      $display("FAIL bp_transfers: got %0d want 1", transfers);
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; opcode = 3'b101; A = 16'h00F0; B = 16'h0F00;
    tick();
    vec_count++;
    if (out_valid !== 1'b1 || result !== 16'h0FF0 || in_ready !== 1'b1) begin
      err_count++;
      $display("FAIL b2b_or: v=%b res=%h in_ready=%b want 1 0ff0 1", out_valid, result, in_ready);
    end
    opcode = 3'b110; A = 16'hFFFF; B = 16'h00FF;
    tick();
    vec_count++;
    if (out_valid !== 1'b1 || result !== 16'hFF00 || zero !== 1'b0) begin
      err_count++;
      $display("FAIL b2b_xor: v=%b res=%h z=%b want 1 ff00 0", out_valid, result, zero);
    end
    opcode = 3'b000; A = 16'h1234; B = 16'h1111;
    tick();
    vec_count++;
    if (out_valid !== 1'b1 || result !== 16'h2345 || carryout !== 1'b0) begin
      err_count++;
      $display("FAIL b2b_add: v=%b res=%h c=%b want 1 2345 0", out_valid, result, carryout);
    end
    in_valid = 1'b0;
    tick();
    vec_count++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      err_count++;
      $display("FAIL b2b_drain: v=%b busy=%b want 0/0", out_valid, busy);
    end
    $display("test_back_to_back: done");
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_arith();
    test_shift();
    test_backpressure();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule : tb_myalu_pipe
